t02_wishbone_sram_responder: RTL and testbench
==============================================

Name: t02_wishbone_sram_responder

Overview:
- Wishbone classic-cycle subordinate: the responder at the far end of the bus driven by the team's Wishbone manager.
- Bus-side naming is from the subordinate's view: the manager's ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O arrive as ADR_I/DAT_I/SEL_I/WE_I/STB_I/CYC_I, and this block drives DAT_O/ACK_O back into the manager's DAT_I/ACK_I.
- Backs a word-organised on-chip RAM window at BASE_ADDR with byte-lane writes and a programmable number of wait states.
- Flags out-of-window accesses with ERR_O.
- Used as the memory model for CPU bring-up and as a real scratch RAM.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte address of word 0; must be 4-byte aligned.
- ADDR_WIDTH, 8, word-index width; DEPTH = 2**ADDR_WIDTH words (window = 4*DEPTH bytes).
- WAIT_STATES, 1, extra cycles between accept and response; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- CYC_I  input  1  bus cycle valid.
- STB_I  input  1  transfer strobe.
- WE_I  input  1  1 = write, 0 = read.
- ADR_I  input  32  byte address; bits [1:0] ignored.
- DAT_I  input  32  write data.
- SEL_I  input  4  byte-lane enables; bit k covers DAT_I[8k+7:8k].
- DAT_O  output  32  read data.
- ACK_O  output  1  successful-termination pulse.
- ERR_O  output  1  error-termination pulse.

Behaviour:
- Reset (async, while rst = 1):
  - ACK_O = 0, ERR_O = 0, DAT_O = 0.
  - FSM in IDLE, wait counter = 0.
  - All RAM words cleared to 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with CYC_I & STB_I = 1, latch ADR_I, DAT_I, SEL_I, WE_I and the in-window flag. This edge is the accept edge, E0.
  - Next state is WAIT with counter = WAIT_STATES, or RESP directly when WAIT_STATES = 0.
- Window decode:
  - In-window iff BASE_ADDR <= ADR_I < BASE_ADDR + 4*DEPTH, compared at full 32-bit width with no wrap.
  - Word index = (ADR_I - BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits.
- WAIT:
  - Counter decrements once per cycle; leave for RESP on the edge where the counter reaches 1.
  - If CYC_I = 0 or STB_I = 0 is sampled at any edge in WAIT, the transfer is aborted: return to IDLE, no ACK_O or ERR_O, no RAM write.
- Response timing:
  - The response edge is E0 + WAIT_STATES.
  - ACK_O or ERR_O is high for exactly one cycle: the cycle after the response edge, i.e. WAIT_STATES+1 cycles after the cycle in which STB_I first rose.
- In-window write:
  - At the response edge, write each byte lane k with SEL_I[k] = 1.
  - SEL_I = 4'b0000 still ACKs but changes nothing.
  - DAT_O = 0 during the ACK cycle.
- In-window read:
  - At the response edge, DAT_O is loaded with the full addressed word; SEL_I is ignored for reads.
  - DAT_O is valid during the ACK cycle and returns to 0 the following cycle.
- Out-of-window access:
  - ERR_O pulses instead of ACK_O, RAM is untouched, DAT_O = 0.
  - ACK_O and ERR_O are never high together.
- RESP:
  - Always returns to IDLE after one cycle, whatever STB_I is.
  - The manager must drop STB_I in the cycle after it samples ACK_O/ERR_O.
  - Back-to-back transfers are accepted every WAIT_STATES+2 cycles.
- Inputs sampled outside IDLE (other than the abort check) are ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.
- rst asserted mid-transfer: outputs drop to 0 immediately, any pending write is discarded, and RAM is cleared.

Test Plan:
1. Reset and hold rst = 1 for 3 cycles -> ACK_O = 0, ERR_O = 0, DAT_O = 0; a read of BASE+0x0 after release returns 32'h0000_0000.
2. WAIT_STATES = 1: write 32'hDEAD_BEEF to 32'h3000_0010 with SEL = 4'hF (STB_I rises in cycle 0) -> ACK_O high only in cycle 2. Then read 32'h3000_0010 -> DAT_O = 32'hDEAD_BEEF in its ACK cycle and 0 one cycle later.
3. Byte-lane write of 32'h0000_AA00 with SEL = 4'b0010 to 32'h3000_0010 -> subsequent read returns 32'hDEAD_AAEF. A write with SEL = 4'b0000 -> ACK_O pulses and the word is unchanged.
4. Out-of-window accesses: read 32'h3000_0400 and write 32'h2FFF_FFFC -> ERR_O pulses for one cycle with ACK_O = 0; RAM word 0 still reads 0 and word 255 (32'h3000_03FC) is unaffected.
5. WAIT_STATES = 3: STB_I drops during the 2nd wait cycle of a write of 32'h1234_5678 to 32'h3000_0020 -> no ACK_O or ERR_O; a later read returns 0. A full-length write then ACKs in cycle 4.
6. Assert rst during the WAIT of a write of 32'hCAFE_F00D -> ACK_O stays 0; after release, a read of that address returns 0. Back-to-back reads with WAIT_STATES = 0 -> ACK_O pulses at a 2-cycle period.

Source files
------------

// File: rtl/t02_wishbone_sram_responder_if.sv
// Wishbone classic-cycle bus bundle between a manager and the SRAM responder.
// Signal names follow the responder's view of the bus (manager outputs arrive as *_I).
interface t02_wishbone_sram_responder_if;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [31:0] ADR_I;
    logic [31:0] DAT_I;
    logic [3:0]  SEL_I;
    logic [31:0] DAT_O;
    logic        ACK_O;
    logic        ERR_O;

    modport slave (
        input  CYC_I,
        input  STB_I,
        input  WE_I,
        input  ADR_I,
        input  DAT_I,
        input  SEL_I,
        output DAT_O,
        output ACK_O,
        output ERR_O
    );

    modport master (
        output CYC_I,
        output STB_I,
        output WE_I,
        output ADR_I,
        output DAT_I,
        output SEL_I,
        input  DAT_O,
        input  ACK_O,
        input  ERR_O
    );
endinterface

// File: rtl/t02_wishbone_sram_responder.sv
// Wishbone classic-cycle subordinate backing a word-organised RAM window with
// byte-lane writes, programmable wait states and ERR_O on out-of-window accesses.
module t02_wishbone_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          ADDR_WIDTH  = 8,
    parameter int          WAIT_STATES = 1
) (
    input logic                            clk,
    input logic                            rst,
    t02_wishbone_sram_responder_if.slave   bus
);

    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [32:0] WIN_END   = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
    localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;

    // Transaction captured at the accept edge; inputs are ignored after that.
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdat_q;
    logic [3:0]              sel_q;
    logic                    we_q;
    logic                    hit_q;

    logic                    ack_q;
    logic                    err_q;
    logic [31:0]             dat_q;

    logic [31:0]             mem [DEPTH];

    logic                    req;
    logic                    in_hit;
    logic [ADDR_WIDTH-1:0]   in_idx;
    logic [ADDR_WIDTH-1:0]   cur_idx;
    logic [31:0]             cur_wdat;
    logic [3:0]              cur_sel;
    logic                    cur_we;
    logic                    cur_hit;
    logic                    respond;
    logic                    do_write;

    // With zero wait states the accept edge is also the response edge, so the
    // transaction fields come straight from the bus while still in IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; a missed
        // branch would otherwise infer a latch.
        req      = bus.CYC_I & bus.STB_I;
        in_hit   = ({1'b0, bus.ADR_I} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, bus.ADR_I} <  WIN_END);
        in_idx   = ADDR_WIDTH'((bus.ADR_I - BASE_ADDR) >> 2);
        cur_idx  = idx_q;
        cur_wdat = wdat_q;
        cur_sel  = sel_q;
        cur_we   = we_q;
        cur_hit  = hit_q;
        if (state == S_IDLE) begin
            cur_idx  = in_idx;
            cur_wdat = bus.DAT_I;
            cur_sel  = bus.SEL_I;
            cur_we   = bus.WE_I;
            cur_hit  = in_hit;
        end
        respond  = req && (((state == S_IDLE) && ZERO_WAIT) ||
                           ((state == S_WAIT) && (cnt == 4'd1)));
        do_write = respond && cur_hit && cur_we;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            idx_q  <= '0;
            wdat_q <= 32'h0;
            sel_q  <= 4'h0;
            we_q   <= 1'b0;
            hit_q  <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            dat_q  <= 32'h0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= 32'h0;
            if (respond) begin
                ack_q <= cur_hit;
                err_q <= !cur_hit;
                dat_q <= (cur_hit && !cur_we) ? mem[cur_idx] : 32'h0;
            end

            case (state)
                S_IDLE: begin
                    if (req) begin
                        idx_q  <= in_idx;
                        wdat_q <= bus.DAT_I;
                        sel_q  <= bus.SEL_I;
                        we_q   <= bus.WE_I;
                        hit_q  <= in_hit;
                        if (ZERO_WAIT) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd1) begin
                        state <= S_RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the RAM is reset on purpose: it must read back as zero after
        // every reset, so it cannot map onto a plain SRAM macro.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (cur_sel[k]) begin
                    mem[cur_idx][8*k +: 8] <= cur_wdat[8*k +: 8];
                end
            end
        end
    end

    assign bus.ACK_O = ack_q;
    assign bus.ERR_O = err_q;
    assign bus.DAT_O = dat_q;

endmodule

// File: tb/tb_t02_wishbone_sram_responder.sv
// Directed bench for the Wishbone SRAM responder: three instances cover
// WAIT_STATES = 0, 1 and 3 on a shared clock and reset.
module tb_t02_wishbone_sram_responder;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          dsel;

    logic        obs_ack;
    logic        obs_err;
    logic [31:0] obs_dat;

    int total;
    int bad;

    int          r_ack_cyc;
    int          r_ack_n;
    int          r_err_cyc;
    int          r_err_n;
    logic [31:0] r_rd;
    logic [31:0] r_rd_next;
    logic        r_both;

    t02_wishbone_sram_responder_if bus0();
    t02_wishbone_sram_responder_if bus1();
    t02_wishbone_sram_responder_if bus3();

    t02_wishbone_sram_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    t02_wishbone_sram_responder #(.WAIT_STATES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    t02_wishbone_sram_responder #(.WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    assign bus0.CYC_I = cyc & (dsel == 0);
    assign bus0.STB_I = stb & (dsel == 0);
    assign bus0.WE_I  = we;
    assign bus0.ADR_I = adr;
    assign bus0.DAT_I = dat;
    assign bus0.SEL_I = sel;
    assign bus1.CYC_I = cyc & (dsel == 1);
    assign bus1.STB_I = stb & (dsel == 1);
    assign bus1.WE_I  = we;
    assign bus1.ADR_I = adr;
    assign bus1.DAT_I = dat;
    assign bus1.SEL_I = sel;
    assign bus3.CYC_I = cyc & (dsel == 3);
    assign bus3.STB_I = stb & (dsel == 3);
    assign bus3.WE_I  = we;
    assign bus3.ADR_I = adr;
    assign bus3.DAT_I = dat;
    assign bus3.SEL_I = sel;

    always_comb begin
        obs_ack = bus1.ACK_O;
        obs_err = bus1.ERR_O;
        obs_dat = bus1.DAT_O;
        if (dsel == 0) begin
            obs_ack = bus0.ACK_O;
            obs_err = bus0.ERR_O;
            obs_dat = bus0.DAT_O;
        end else if (dsel == 3) begin
            obs_ack = bus3.ACK_O;
            obs_err = bus3.ERR_O;
            obs_dat = bus3.DAT_O;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transfer; cycle 0 is the cycle in which STB_I rises. The manager
    // drops STB_I the cycle after it sees a termination, or at abort_at.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int abort_at);
        int resp_c;
        resp_c    = -1;
        r_ack_cyc = -1;
        r_ack_n   = 0;
        r_err_cyc = -1;
        r_err_n   = 0;
        r_rd      = 32'h0;
        r_rd_next = 32'h0;
        r_both    = 1'b0;
        @(posedge clk); #1;
        we = w; adr = a; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == abort_at) begin
                cyc = 1'b0;
                stb = 1'b0;
            end
            @(negedge clk);
            if (obs_ack && obs_err) r_both = 1'b1;
            if (resp_c >= 0 && c == resp_c + 1) r_rd_next = obs_dat;
            if (obs_ack) begin
                if (r_ack_cyc < 0) r_ack_cyc = c;
                r_ack_n++;
            end
            if (obs_err) begin
                if (r_err_cyc < 0) r_err_cyc = c;
                r_err_n++;
            end
            if ((obs_ack || obs_err) && resp_c < 0) begin
                resp_c = c;
                r_rd   = obs_dat;
            end
            @(posedge clk); #1;
            if (resp_c >= 0) begin
                cyc = 1'b0;
                stb = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus0.ACK_O, bus1.ACK_O, bus3.ACK_O, bus0.ERR_O, bus1.ERR_O, bus3.ERR_O} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: ack/err=%b required 000000",
                     {bus0.ACK_O, bus1.ACK_O, bus3.ACK_O, bus0.ERR_O, bus1.ERR_O, bus3.ERR_O});
        end
        total++;
        if ((bus0.DAT_O | bus1.DAT_O | bus3.DAT_O) !== 32'h0) begin
            bad++;
            $display("FAIL reset_dat: dat or=%h required 00000000", bus0.DAT_O | bus1.DAT_O | bus3.DAT_O);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        dsel = 1;
        xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, -1);
        total++;
        if (r_ack_cyc !== 2 || r_rd !== 32'h0) begin
            bad++;
            $display("FAIL reset_read: ack_cyc=%0d dat=%h required 2 00000000", r_ack_cyc, r_rd);
        end
    endtask

    task automatic test_write_read();
        dsel = 1;
        xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, -1);
        total++;
        if (r_ack_cyc !== 2 || r_ack_n !== 1 || r_err_n !== 0) begin
            bad++;
            $display("FAIL write_ack: cyc=%0d n=%0d err_n=%0d required 2 1 0", r_ack_cyc, r_ack_n, r_err_n);
        end
        total++;
        if (r_rd !== 32'h0) begin
            bad++;
            $display("FAIL write_dat_zero: dat=%h required 00000000", r_rd);
        end
        xfer(1'b0, 32'h3000_0010, 32'h0, 4'h0, -1);
        total++;
        if (r_ack_cyc !== 2 || r_rd !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL read_back: cyc=%0d dat=%h required 2 deadbeef", r_ack_cyc, r_rd);
        end
        total++;
        if (r_rd_next !== 32'h0) begin
            bad++;
            $display("FAIL read_dat_drop: dat=%h required 00000000", r_rd_next);
        end
    endtask

    task automatic test_byte_lanes();
        dsel = 1;
        xfer(1'b1, 32'h3000_0010, 32'h0000_AA00, 4'b0010, -1);
        xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, -1);
        total++;
        if (r_rd !== 32'hDEAD_AAEF) begin
            bad++;
            $display("FAIL byte_lane: dat=%h required deadaaef", r_rd);
        end
        xfer(1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'b0000, -1);
        total++;
        if (r_ack_cyc !== 2 || r_ack_n !== 1) begin
            bad++;
            $display("FAIL sel_zero_ack: cyc=%0d n=%0d required 2 1", r_ack_cyc, r_ack_n);
        end
        xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, -1);
        total++;
        if (r_rd !== 32'hDEAD_AAEF) begin
            bad++;
            $display("FAIL sel_zero_keep: dat=%h required deadaaef", r_rd);
        end
    endtask

    task automatic test_out_of_window();
        dsel = 1;
        xfer(1'b1, 32'h3000_03FC, 32'hA5A5_5A5A, 4'hF, -1);
        xfer(1'b0, 32'h3000_0400, 32'h0, 4'hF, -1);
        total++;
        if (r_err_cyc !== 2 || r_err_n !== 1 || r_ack_n !== 0 || r_both !== 1'b0 || r_rd !== 32'h0) begin
            bad++;
            $display("FAIL oow_read: err_cyc=%0d err_n=%0d ack_n=%0d both=%b dat=%h required 2 1 0 0 0",
                     r_err_cyc, r_err_n, r_ack_n, r_both, r_rd);
        end
        xfer(1'b1, 32'h2FFF_FFFC, 32'h1111_2222, 4'hF, -1);
        total++;
        if (r_err_cyc !== 2 || r_err_n !== 1 || r_ack_n !== 0) begin
            bad++;
            $display("FAIL oow_write: err_cyc=%0d err_n=%0d ack_n=%0d required 2 1 0", r_err_cyc, r_err_n, r_ack_n);
        end
        xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, -1);
        total++;
        if (r_ack_cyc !== 2 || r_rd !== 32'h0) begin
            bad++;
            $display("FAIL oow_word0: cyc=%0d dat=%h required 2 00000000", r_ack_cyc, r_rd);
        end
        xfer(1'b0, 32'h3000_03FC, 32'h0, 4'hF, -1);
        total++;
        if (r_ack_cyc !== 2 || r_rd !== 32'hA5A5_5A5A) begin
            bad++;
            $display("FAIL oow_word255: cyc=%0d dat=%h required 2 a5a55a5a", r_ack_cyc, r_rd);
        end
    endtask

    task automatic test_abort();
        dsel = 3;
        xfer(1'b1, 32'h3000_0020, 32'h1234_5678, 4'hF, 2);
        total++;
        if (r_ack_n !== 0 || r_err_n !== 0) begin
            bad++;
            $display("FAIL abort_silent: ack_n=%0d err_n=%0d required 0 0", r_ack_n, r_err_n);
        end
        xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, -1);
        total++;
        if (r_ack_cyc !== 4 || r_rd !== 32'h0) begin
            bad++;
            $display("FAIL abort_no_write: cyc=%0d dat=%h required 4 00000000", r_ack_cyc, r_rd);
        end
        xfer(1'b1, 32'h3000_0020, 32'h1234_5678, 4'hF, -1);
        total++;
        if (r_ack_cyc !== 4 || r_ack_n !== 1) begin
            bad++;
            $display("FAIL ws3_ack: cyc=%0d n=%0d required 4 1", r_ack_cyc, r_ack_n);
        end
        xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, -1);
        total++;
        if (r_rd !== 32'h1234_5678) begin
            bad++;
            $display("FAIL ws3_read: dat=%h required 12345678", r_rd);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        dsel = 3;
        acks = 0;
        @(posedge clk); #1;
        we = 1'b1; adr = 32'h3000_0030; dat = 32'hCAFE_F00D; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (obs_ack || obs_err) acks++;
            @(posedge clk); #1;
            if (c == 1) begin
                cyc = 1'b0;
                stb = 1'b0;
            end
            if (c == 3) rst = 1'b0;
        end
        total++;
        if (acks !== 0) begin
            bad++;
            $display("FAIL rst_mid_ack: terminations=%0d required 0", acks);
        end
        xfer(1'b0, 32'h3000_0030, 32'h0, 4'hF, -1);
        total++;
        if (r_ack_cyc !== 4 || r_rd !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid_read: cyc=%0d dat=%h required 4 00000000", r_ack_cyc, r_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        int         dat_bad;
        dsel = 0;
        xfer(1'b1, 32'h3000_0040, 32'h0BAD_F00D, 4'hF, -1);
        total++;
        if (r_ack_cyc !== 1 || r_ack_n !== 1) begin
            bad++;
            $display("FAIL ws0_write_ack: cyc=%0d n=%0d required 1 1", r_ack_cyc, r_ack_n);
        end
        pat     = 8'h0;
        dat_bad = 0;
        @(posedge clk); #1;
        we = 1'b0; adr = 32'h3000_0040; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            pat[c] = obs_ack;
            if (obs_ack && obs_dat !== 32'h0BAD_F00D) dat_bad++;
            @(posedge clk); #1;
        end
        cyc = 1'b0;
        stb = 1'b0;
        total++;
        if (pat !== 8'hAA) begin
            bad++;
            $display("FAIL b2b_period: ack pattern=%b required 10101010", pat);
        end
        total++;
        if (dat_bad !== 0) begin
            bad++;
            $display("FAIL b2b_data: wrong words=%0d required 0", dat_bad);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        adr   = 32'h0;
        dat   = 32'h0;
        sel   = 4'h0;
        dsel  = 1;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_out_of_window();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
